// File: rtl/uart_pkt_pkg.sv
// ============================================================================
// Module   : uart_pkt_pkg
// Brief    : Shared constants and types for the UART packet deframer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkt_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    localparam logic [1:0] ERR_CHK     = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/uart_pkt_timer.sv
// ============================================================================
// Module   : uart_pkt_timer
// Brief    : Clearable inter-byte timeout counter with a combinational expiry strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pkt_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;

    // Saturates at the terminal count so a stalled enable cannot wrap around.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_enable && (r_cnt_q != c_last)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_expire = i_enable && (r_cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_pkt_rx.sv
// ============================================================================
// Module   : uart_pkt_rx
// Brief    : Deframes SOF/LEN/payload/CHK packets from a UART byte stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic       pay_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    state_t     r_state_q,     w_state_d;
    logic       r_rdy_prev_q,  w_rdy_prev_d;
    logic [7:0] r_rem_q,       w_rem_d;
    logic [7:0] r_chk_q,       w_chk_d;
    logic [7:0] r_pay_data_q,  w_pay_data_d;
    logic       r_pay_valid_q, w_pay_valid_d;
    logic       r_pay_last_q,  w_pay_last_d;
    logic       r_pkt_ok_q,    w_pkt_ok_d;
    logic       r_pkt_err_q,   w_pkt_err_d;
    logic [1:0] r_err_code_q,  w_err_code_d;
    logic       r_busy_q,      w_busy_d;

    logic w_accept;
    logic w_expire;

    assign w_accept = rx_ready && !r_rdy_prev_q;

    uart_pkt_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept || (r_state_q == IDLE)),
        .i_enable (r_state_q != IDLE),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_rdy_prev_d  = rx_ready;
        w_rem_d       = r_rem_q;
        w_chk_d       = r_chk_q;
        w_pay_data_d  = r_pay_data_q;
        w_pay_valid_d = 1'b0;
        w_pay_last_d  = 1'b0;
        w_pkt_ok_d    = 1'b0;
        w_pkt_err_d   = 1'b0;
        w_err_code_d  = r_err_code_q;

        // An accepted byte takes priority over a coincident timeout expiry.
        if (w_accept) begin
            case (r_state_q)
                IDLE: begin
                    if (rx_data == SOF_BYTE) begin
                        w_state_d = LEN;
                    end
                end
                LEN: begin
                    if ((rx_data == 8'd0) || (rx_data > c_max_len)) begin
                        w_pkt_err_d  = 1'b1;
                        w_err_code_d = ERR_LEN;
                        w_state_d    = IDLE;
                    end else begin
                        w_rem_d   = rx_data;
                        w_chk_d   = rx_data;
                        w_state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    w_pay_valid_d = 1'b1;
                    w_pay_data_d  = rx_data;
                    w_chk_d       = r_chk_q ^ rx_data;
                    w_rem_d       = r_rem_q - 8'd1;
                    if (r_rem_q == 8'd1) begin
                        w_pay_last_d = 1'b1;
                        w_state_d    = CHK;
                    end
                end
                CHK: begin
                    if (rx_data == r_chk_q) begin
                        w_pkt_ok_d = 1'b1;
                    end else begin
                        w_pkt_err_d  = 1'b1;
                        w_err_code_d = ERR_CHK;
                    end
                    w_state_d = IDLE;
                end
                default: w_state_d = IDLE;
            endcase
        end else if (w_expire) begin
            w_pkt_err_d  = 1'b1;
            w_err_code_d = ERR_TIMEOUT;
            w_state_d    = IDLE;
        end

        w_busy_d = (w_state_d != IDLE);
    end

    // The edge history resets high so a strobe held through reset is not a byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q     <= IDLE;
            r_rdy_prev_q  <= 1'b1;
            r_rem_q       <= 8'd0;
            r_chk_q       <= 8'd0;
            r_pay_data_q  <= 8'd0;
            r_pay_valid_q <= 1'b0;
            r_pay_last_q  <= 1'b0;
            r_pkt_ok_q    <= 1'b0;
            r_pkt_err_q   <= 1'b0;
            r_err_code_q  <= 2'd0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_rdy_prev_q  <= w_rdy_prev_d;
            r_rem_q       <= w_rem_d;
            r_chk_q       <= w_chk_d;
            r_pay_data_q  <= w_pay_data_d;
            r_pay_valid_q <= w_pay_valid_d;
            r_pay_last_q  <= w_pay_last_d;
            r_pkt_ok_q    <= w_pkt_ok_d;
            r_pkt_err_q   <= w_pkt_err_d;
            r_err_code_q  <= w_err_code_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign pay_data  = r_pay_data_q;
    assign pay_valid = r_pay_valid_q;
    assign pay_last  = r_pay_last_q;
    assign pkt_ok    = r_pkt_ok_q;
    assign pkt_err   = r_pkt_err_q;
    assign err_code  = r_err_code_q;
    assign busy      = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_pkt_rx.sv
// ============================================================================
// Module   : tb_uart_pkt_rx
// Brief    : Scoreboard bench for the UART packet deframer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_pkt_rx;

    localparam int c_timeout = 40;
    localparam int c_max_len = 16;

    localparam logic [2:0] c_k_pay = 3'b100;
    localparam logic [2:0] c_k_ok  = 3'b010;
    localparam logic [2:0] c_k_err = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
        logic       last;
        logic [1:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    int   err_cyc  = 0;

    uart_pkt_rx #(
        .SOF_BYTE    (8'hA5),
        .MAX_LEN     (c_max_len),
        .TIMEOUT_CYC (c_timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_last  (pay_last),
        .pkt_ok    (pkt_ok),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_pay(input logic [7:0] d, input logic l);
        exp_q.push_back('{kind: c_k_pay, data: d, last: l, code: 2'd0});
    endtask

    task automatic push_ok();
        exp_q.push_back('{kind: c_k_ok, data: 8'd0, last: 1'b0, code: 2'd0});
    endtask

    task automatic push_err(input logic [1:0] c);
        exp_q.push_back('{kind: c_k_err, data: 8'd0, last: 1'b0, code: c});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        last_acc = cyc;
        tick(hold - 1);
        rx_ready = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        tick(2);
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Every output strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (pay_valid || pkt_ok || pkt_err) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_evt", {29'd0, pay_valid, pkt_ok, pkt_err}, 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                check_eq("evt_kind", {29'd0, pay_valid, pkt_ok, pkt_err}, {29'd0, m_e.kind});
                if (pay_valid) begin
                    check_eq("pay_data", {24'd0, pay_data}, {24'd0, m_e.data});
                    check_eq("pay_last", {31'd0, pay_last}, {31'd0, m_e.last});
                end
                if (pkt_err) begin
                    check_eq("err_code", {30'd0, err_code}, {30'd0, m_e.code});
                    err_cyc = cyc;
                end
            end
        end
    end

    initial begin
        logic [7:0] chk;
        rst      = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        tick(3);
        check_eq("rst_pay_data",  {24'd0, pay_data}, 32'd0);
        check_eq("rst_pay_valid", {31'd0, pay_valid}, 32'd0);
        check_eq("rst_pay_last",  {31'd0, pay_last}, 32'd0);
        check_eq("rst_pkt_ok",    {31'd0, pkt_ok}, 32'd0);
        check_eq("rst_pkt_err",   {31'd0, pkt_err}, 32'd0);
        check_eq("rst_err_code",  {30'd0, err_code}, 32'd0);
        check_eq("rst_busy",      {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick(2);

        // Good frame
        send_byte(8'hA5, 1);
        check_eq("busy_after_sof", {31'd0, busy}, 32'd1);
        send_byte(8'h03, 1);
        push_pay(8'h11, 1'b0); send_byte(8'h11, 1);
        push_pay(8'h22, 1'b0); send_byte(8'h22, 1);
        push_pay(8'h33, 1'b1); send_byte(8'h33, 1);
        push_ok();             send_byte(8'h03, 1);
        wait_drain("drain_good");
        check_eq("busy_idle_good", {31'd0, busy}, 32'd0);

        // Bad checksum
        send_byte(8'hA5, 1); send_byte(8'h03, 1);
        push_pay(8'h11, 1'b0); send_byte(8'h11, 1);
        push_pay(8'h22, 1'b0); send_byte(8'h22, 1);
        push_pay(8'h33, 1'b1); send_byte(8'h33, 1);
        push_err(2'd0);        send_byte(8'h04, 1);
        wait_drain("drain_badchk");

        // Bad LEN: zero, MAX_LEN+1, and a LEN equal to SOF is not re-taken as SOF
        send_byte(8'hA5, 1); push_err(2'd1); send_byte(8'h00, 1);
        wait_drain("drain_len0");
        check_eq("busy_len0", {31'd0, busy}, 32'd0);
        send_byte(8'hA5, 1); push_err(2'd1); send_byte(8'(c_max_len + 1), 1);
        wait_drain("drain_lenmax1");
        check_eq("busy_lenmax1", {31'd0, busy}, 32'd0);
        send_byte(8'hA5, 1); push_err(2'd1); send_byte(8'hA5, 1);
        wait_drain("drain_len_sof");
        check_eq("busy_len_sof", {31'd0, busy}, 32'd0);

        // LEN exactly MAX_LEN is accepted
        send_byte(8'hA5, 1);
        send_byte(8'(c_max_len), 1);
        chk = 8'(c_max_len);
        for (int i = 0; i < c_max_len; i++) begin
            push_pay(8'(i * 7 + 3), (i == c_max_len - 1));
            chk = chk ^ 8'(i * 7 + 3);
            send_byte(8'(i * 7 + 3), 1);
        end
        push_ok(); send_byte(chk, 1);
        wait_drain("drain_maxlen");

        // Leading noise ignored, single-byte payload
        send_byte(8'h55, 1);
        check_eq("busy_noise", {31'd0, busy}, 32'd0);
        send_byte(8'hA5, 1); send_byte(8'h01, 1);
        push_pay(8'h7E, 1'b1); send_byte(8'h7E, 1);
        push_ok();             send_byte(8'h7F, 1);
        wait_drain("drain_single");

        // Timeout, then a clean frame
        send_byte(8'hA5, 1); send_byte(8'h02, 1);
        push_pay(8'h10, 1'b0); send_byte(8'h10, 1);
        push_err(2'd2);
        wait_drain("drain_timeout");
        check_eq("timeout_latency", err_cyc - last_acc, c_timeout);
        check_eq("busy_timeout", {31'd0, busy}, 32'd0);
        send_byte(8'hA5, 1); send_byte(8'h01, 1);
        push_pay(8'hFF, 1'b1); send_byte(8'hFF, 1);
        push_ok();             send_byte(8'hFE, 1);
        wait_drain("drain_after_to");

        // A byte landing on the expiry cycle wins over the timeout
        send_byte(8'hA5, 1); send_byte(8'h02, 1);
        push_pay(8'h10, 1'b0); send_byte(8'h10, 1);
        while (cyc < last_acc + c_timeout - 1) tick(1);
        push_pay(8'h20, 1'b1);
        rx_data  = 8'h20;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        push_ok(); send_byte(8'h32, 1);
        wait_drain("drain_byte_wins");

        // Reset mid-payload, with the strobe held high through reset
        send_byte(8'hA5, 1); send_byte(8'h04, 1);
        push_pay(8'h01, 1'b0); send_byte(8'h01, 1);
        push_pay(8'h02, 1'b0); send_byte(8'h02, 1);
        wait_drain("drain_pre_rst");
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        rst      = 1'b0;
        tick(2);
        check_eq("midrst_pay_data", {24'd0, pay_data}, 32'd0);
        check_eq("midrst_busy",     {31'd0, busy}, 32'd0);
        check_eq("midrst_err",      {31'd0, pkt_err}, 32'd0);
        rst = 1'b1;
        tick(3);
        check_eq("held_rdy_busy", {31'd0, busy}, 32'd0);
        rx_ready = 1'b0;
        tick(2);
        wait_drain("drain_post_rst");

        // Long strobes: each byte counted once
        send_byte(8'hA5, 5); send_byte(8'h02, 5);
        push_pay(8'hAA, 1'b0); send_byte(8'hAA, 5);
        push_pay(8'hBB, 1'b1); send_byte(8'hBB, 5);
        push_ok();             send_byte(8'h13, 5);
        wait_drain("drain_hold5");
        check_eq("busy_end", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_pkt_rx.md
Name: uart_pkt_rx

Overview:
Packet deframer directly downstream of the UART receiver. Consumes the received byte stream (rx_data/rx_ready) and recognises frames of the form SOF, LEN, payload, CHK. Streams validated-position payload bytes to the consumer and reports per-frame success or error. Sits between the UART core and the command/register layer.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker
MAX_LEN, 16, maximum payload length accepted (1..255)
TIMEOUT_CYC, 100000, clocks allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, synchronous, active-low (rst==0 resets)
rx_data  in  8  byte from UART receiver, valid when rx_ready high
rx_ready  in  1  receiver byte-available strobe; byte accepted on its rising edge
pay_data  out  8  payload byte
pay_valid  out  1  one-cycle strobe per payload byte
pay_last  out  1  high with pay_valid on final payload byte
pkt_ok  out  1  one-cycle pulse: frame complete, checksum match
pkt_err  out  1  one-cycle pulse: frame aborted
err_code  out  2  cause, valid with pkt_err: 0 bad checksum, 1 bad LEN, 2 timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst==0 at clock edge): state IDLE; pay_data=0, pay_valid=0, pay_last=0, pkt_ok=0, pkt_err=0, err_code=0, busy=0; counters and checksum cleared. The rx_ready history register resets to 1, so a level held through reset is not taken as a byte. Reset mid-frame discards the frame with no pulse.
- Byte accept: a byte is accepted in cycle N when rx_ready=1 and the registered previous rx_ready=0. rx_data is sampled in that same cycle. Only one byte per rising edge, regardless of how long the strobe stays high.
- All outputs are registered. The response to a byte accepted in cycle N appears in cycle N+1. Strobes last exactly one cycle.
- FSM states: IDLE, LEN, PAYLOAD, CHK.
  - IDLE: an accepted byte equal to SOF_BYTE goes to LEN. Any other byte is silently ignored.
  - LEN: if byte is 0 or greater than MAX_LEN, pulse pkt_err with err_code=1 and go to IDLE. That byte is not re-examined as SOF. Otherwise store remaining=LEN, set chk=LEN, go to PAYLOAD.
  - PAYLOAD: each byte asserts pay_valid with pay_data=byte. chk^=byte, remaining decrements. When remaining reaches 1, also assert pay_last and go to CHK.
  - CHK: if byte==chk, pulse pkt_ok; else pulse pkt_err with err_code=0. Go to IDLE in either case.
- Checksum: 8-bit XOR of LEN and all payload bytes. SOF is excluded.
- Timeout: the inter-byte counter is cleared on every accepted byte and increments each cycle while busy. On reaching TIMEOUT_CYC-1, pulse pkt_err with err_code=2 and go to IDLE. If a byte is accepted in the same cycle as expiry, the byte wins and the counter clears.
- Payload already streamed is not retracted on error. The consumer must discard on pkt_err.
- No backpressure: the byte rate is far below the clock rate, so the consumer must accept every pay_valid.
- busy is high one cycle after leaving IDLE and low one cycle after returning to IDLE.

Decomposition:
- Shared package uart_pkt_pkg holds:
  - SOF default
  - state enum (IDLE/LEN/PAYLOAD/CHK)
  - err_code constants ERR_CHK=0, ERR_LEN=1, ERR_TIMEOUT=2
- One sub-module, uart_pkt_timer: a clearable inter-byte timeout counter with an expiry strobe, parameterised by TIMEOUT_CYC.
- Edge detection and the FSM stay in the top block.

Test Plan:
- Send A5,03,11,22,33,03 -> three pay_valid with 11,22,33; pay_last on 33; pkt_ok one cycle after the 03 CHK byte; no pkt_err.
- Send A5,03,11,22,33,04 -> three payload strobes, then pkt_err=1 with err_code=0; pkt_ok stays 0.
- Send A5,00, then separately A5 with LEN=MAX_LEN+1 -> pkt_err with err_code=1 after each LEN byte; no pay_valid; busy returns to 0.
- Send 55,A5,01,7E,7F (checksum 01^7E) -> leading 55 ignored; single payload 7E with pay_last; pkt_ok.
- Send A5,02,10, then idle TIMEOUT_CYC cycles -> pkt_err with err_code=2; busy=0; the next A5,01,FF,FE frame gives pkt_ok.
- Hold rx_ready high 5 cycles per byte, and separately assert rst=0 mid-PAYLOAD -> each byte counted once; reset clears all outputs with no pulse, and the next frame decodes cleanly.
